// File: rtl/hft_pkg.sv
// Shared definitions for the order-generation slice: order-word field layout,
// side encodings, strategy modes and the bot FSM state type.
package hft_pkg;

    // Default field widths of an order word {price, is_buy, is_bot, qty}
    localparam int PRICE_W_DEF = 16;
    localparam int QTY_W_DEF   = 14;

    // Side encodings carried in the is_buy bit
    localparam logic TYPE_BID = 1'b1;
    localparam logic TYPE_ASK = 1'b0;

    // Strategy modes
    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_FRONT = 2'b01,
        MODE_JOIN  = 2'b10,
        MODE_ALT   = 2'b11
    } mode_e;

    // Bot sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EVAL_A = 3'd1,
        ST_EVAL_B = 3'd2,
        ST_SEND   = 3'd3,
        ST_COOL   = 3'd4
    } bot_state_e;

    // Field offsets within an order word, as a function of the quantity width
    function automatic int qty_lsb(input int qty_w);
        return 0 * qty_w;
    endfunction

    function automatic int bot_bit(input int qty_w);
        return qty_w;
    endfunction

    function automatic int side_bit(input int qty_w);
        return qty_w + 1;
    endfunction

    function automatic int price_lsb(input int qty_w);
        return qty_w + 2;
    endfunction

endpackage

// File: rtl/quote_strategy_bot_if.sv
// Bus between the bot, the heap-manager roots, the Bot FIFO and the engine.
// Handshake: bot_valid is a one-cycle write strobe qualifying bot_data; the bot
// only raises it when bot_full, engine_busy and udp_fifo_has_data were all low
// in the cycle that issued the write, so there is no ready back-pressure.
interface quote_strategy_bot_if #(
    parameter int PRICE_W = 16,
    parameter int QTY_W   = 14
) ();
    localparam int ORD_W = PRICE_W + 2 + QTY_W;

    logic [ORD_W-1:0] bid_root;
    logic [ORD_W-1:0] ask_root;
    logic             udp_fifo_has_data;
    logic             engine_busy;
    logic             bot_full;
    logic             fill_valid;
    logic             fill_is_buy;
    logic [QTY_W-1:0] fill_qty;
    logic             bot_valid;
    logic [ORD_W-1:0] bot_data;

    // Bot side
    modport master (
        input  bid_root, ask_root, udp_fifo_has_data, engine_busy, bot_full,
        input  fill_valid, fill_is_buy, fill_qty,
        output bot_valid, bot_data
    );

    // Book / FIFO / engine side
    modport slave (
        output bid_root, ask_root, udp_fifo_has_data, engine_busy, bot_full,
        output fill_valid, fill_is_buy, fill_qty,
        input  bot_valid, bot_data
    );
endinterface

// File: rtl/position_tracker.sv
// Saturating signed net-position accumulator fed by engine fills, with flags
// telling whether one more bot order on each side stays within the limit.
module position_tracker #(
    parameter int POS_W     = 16,
    parameter int QTY_W     = 14,
    parameter int BOT_QTY   = 10,
    parameter int POS_LIMIT = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_fill_valid,
    input  logic                    i_fill_is_buy,
    input  logic [QTY_W-1:0]        i_fill_qty,
    output logic signed [POS_W-1:0] o_position,
    output logic                    o_can_buy,
    output logic                    o_can_sell
);
    // Wide enough to hold position +/- any fill without wrapping
    localparam int XW = ((POS_W > QTY_W) ? POS_W : QTY_W) + 2;

    localparam logic signed [POS_W-1:0] POS_MAX_P   = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [XW-1:0]    POS_MAX_X   = {{(XW-POS_W){1'b0}}, POS_MAX_P};
    localparam logic signed [XW-1:0]    BOT_QTY_X   = XW'(BOT_QTY);
    localparam logic signed [XW-1:0]    POS_LIMIT_X = XW'(POS_LIMIT);

    logic signed [POS_W-1:0] r_position;
    logic signed [XW-1:0]    w_pos_x;
    logic signed [XW-1:0]    w_qty_x;
    logic signed [XW-1:0]    w_sum;
    logic signed [POS_W-1:0] w_next_pos;

    assign w_pos_x = {{(XW-POS_W){r_position[POS_W-1]}}, r_position};
    assign w_qty_x = {{(XW-QTY_W){1'b0}}, i_fill_qty};

    // Next position after this cycle's fill, clamped to the symmetric range
    always_comb begin
        w_sum      = i_fill_is_buy ? (w_pos_x + w_qty_x) : (w_pos_x - w_qty_x);
        w_next_pos = w_sum[POS_W-1:0];
        if (w_sum > POS_MAX_X) begin
            w_next_pos = POS_MAX_P;
        end else if (w_sum < -POS_MAX_X) begin
            w_next_pos = -POS_MAX_P;
        end
    end

    // Accumulate fills every cycle; reset overrides a coincident fill
    always_ff @(posedge clk) begin
        if (rst) begin
            r_position <= '0;
        end else if (i_fill_valid) begin
            r_position <= w_next_pos;
        end
    end

    assign o_position = r_position;
    assign o_can_buy  = (w_pos_x + BOT_QTY_X) <= POS_LIMIT_X;
    assign o_can_sell = (w_pos_x - BOT_QTY_X) >= -POS_LIMIT_X;
endmodule

// File: rtl/quote_strategy_bot.sv
// Order-generation bot: watches best bid/ask, picks a side per strategy mode,
// writes one bot order into the Bot FIFO, then cools down. Yields to UDP
// traffic, a busy engine and a full FIFO; stops quoting a side that would
// push the net position past the limit.
module quote_strategy_bot
    import hft_pkg::*;
#(
    parameter int PRICE_W   = PRICE_W_DEF,
    parameter int QTY_W     = QTY_W_DEF,
    parameter int TICK      = 1,
    parameter int BOT_QTY   = 10,
    parameter int COOLDOWN  = 4,
    parameter int POS_W     = 16,
    parameter int POS_LIMIT = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [1:0]              mode,
    quote_strategy_bot_if.master    bus,
    output logic signed [POS_W-1:0] position,
    output logic [31:0]             orders_sent,
    output logic [2:0]              o_dbg_state
);
    localparam int ORD_W   = PRICE_W + 2 + QTY_W;
    localparam int PX_LSB  = price_lsb(QTY_W);
    localparam int BOT_BIT = bot_bit(QTY_W);
    localparam int CW      = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic [PRICE_W-1:0] TICK_P    = PRICE_W'(TICK);
    localparam logic [QTY_W-1:0]   BOT_QTY_P = QTY_W'(BOT_QTY);
    localparam logic [CW-1:0]      COOL_LOAD = CW'(COOLDOWN - 1);

    bot_state_e         r_state;
    logic               r_bot_valid;
    logic [ORD_W-1:0]   r_bot_data;
    logic [31:0]        r_orders_sent;
    logic               r_last_side;
    logic               r_eval_side;
    logic               r_target_side;
    logic [PRICE_W-1:0] r_target_price;
    logic [CW-1:0]      r_cool_cnt;

    logic [PRICE_W-1:0] w_bid_px;
    logic [PRICE_W-1:0] w_ask_px;
    logic               w_bid_is_bot;
    logic               w_ask_is_bot;
    logic               w_books_ok;
    logic               w_improve;
    logic [PRICE_W-1:0] w_tick_amt;
    logic [PRICE_W:0]   w_bid_sum;
    logic [PRICE_W-1:0] w_ask_tgt;
    logic               w_bid_ok;
    logic               w_ask_ok;
    logic               w_can_buy;
    logic               w_can_sell;
    logic               w_eval_side;
    logic               w_side_ok;
    logic [PRICE_W-1:0] w_side_px;
    logic               w_idle_go;
    logic               w_send_ok;
    logic               w_unused;

    position_tracker #(
        .POS_W     (POS_W),
        .QTY_W     (QTY_W),
        .BOT_QTY   (BOT_QTY),
        .POS_LIMIT (POS_LIMIT)
    ) u_position_tracker (
        .clk           (clk),
        .rst           (rst),
        .i_fill_valid  (bus.fill_valid),
        .i_fill_is_buy (bus.fill_is_buy),
        .i_fill_qty    (bus.fill_qty),
        .o_position    (position),
        .o_can_buy     (w_can_buy),
        .o_can_sell    (w_can_sell)
    );

    // Root fields; the quantity and side bits of the roots are not needed
    assign w_bid_px     = bus.bid_root[PX_LSB +: PRICE_W];
    assign w_ask_px     = bus.ask_root[PX_LSB +: PRICE_W];
    assign w_bid_is_bot = bus.bid_root[BOT_BIT];
    assign w_ask_is_bot = bus.ask_root[BOT_BIT];
    assign w_unused     = ^{bus.bid_root[BOT_BIT-1:0], bus.bid_root[BOT_BIT+1],
                            bus.ask_root[BOT_BIT-1:0], bus.ask_root[BOT_BIT+1]};

    assign w_books_ok = (|bus.bid_root) && (|bus.ask_root);
    assign w_improve  = (mode == MODE_FRONT) || (mode == MODE_ALT);
    assign w_tick_amt = w_improve ? TICK_P : '0;

    // Bid target is computed one bit wider so a carry out disqualifies it
    assign w_bid_sum = {1'b0, w_bid_px} + {1'b0, w_tick_amt};
    assign w_ask_tgt = w_ask_px - w_tick_amt;

    assign w_bid_ok = w_books_ok && !w_bid_is_bot && !w_bid_sum[PRICE_W]
                   && (w_bid_sum[PRICE_W-1:0] < w_ask_px) && w_can_buy;
    assign w_ask_ok = w_books_ok && !w_ask_is_bot
                   && (!w_improve || (w_ask_px > TICK_P))
                   && (w_ask_tgt > w_bid_px) && w_can_sell;

    // ALT starts with the side opposite the last order; other modes start with bid.
    // The second evaluation always looks at the side the first one did not.
    assign w_eval_side = (r_state == ST_EVAL_A)
                       ? ((mode == MODE_ALT) ? ~r_last_side : TYPE_BID)
                       : ~r_eval_side;
    assign w_side_ok   = (w_eval_side == TYPE_BID) ? w_bid_ok : w_ask_ok;
    assign w_side_px   = (w_eval_side == TYPE_BID) ? w_bid_sum[PRICE_W-1:0] : w_ask_tgt;

    assign w_send_ok = !bus.udp_fifo_has_data && !bus.engine_busy && !bus.bot_full;
    assign w_idle_go = enable && (mode != MODE_OFF) && w_send_ok;

    // Bot sequencer: idle -> evaluate two sides -> send -> cool down
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_bot_valid    <= 1'b0;
            r_bot_data     <= '0;
            r_orders_sent  <= '0;
            r_last_side    <= 1'b0;
            r_eval_side    <= 1'b0;
            r_target_side  <= 1'b0;
            r_target_price <= '0;
            r_cool_cnt     <= '0;
        end else begin
            r_bot_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_idle_go) begin
                        r_state <= ST_EVAL_A;
                    end
                end
                ST_EVAL_A: begin
                    r_eval_side <= w_eval_side;
                    if (w_side_ok) begin
                        r_target_side  <= w_eval_side;
                        r_target_price <= w_side_px;
                        r_state        <= ST_SEND;
                    end else begin
                        r_state <= ST_EVAL_B;
                    end
                end
                ST_EVAL_B: begin
                    if (w_side_ok) begin
                        r_target_side  <= w_eval_side;
                        r_target_price <= w_side_px;
                        r_state        <= ST_SEND;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (w_send_ok) begin
                        r_bot_valid   <= 1'b1;
                        r_bot_data    <= {r_target_price, r_target_side, 1'b1, BOT_QTY_P};
                        r_orders_sent <= r_orders_sent + 32'd1;
                        r_last_side   <= r_target_side;
                        r_cool_cnt    <= COOL_LOAD;
                        r_state       <= ST_COOL;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_COOL: begin
                    if (r_cool_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cool_cnt <= r_cool_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bot_valid = r_bot_valid;
    assign bus.bot_data  = r_bot_data;
    assign orders_sent   = r_orders_sent;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_quote_strategy_bot.sv
// Bench for quote_strategy_bot: directed book scenarios followed by random
// ones, each order predicted by a transaction-level model of the quoting rules.
module tb_quote_strategy_bot;
    import hft_pkg::*;

    localparam int PRICE_W   = 16;
    localparam int QTY_W     = 14;
    localparam int ORD_W     = PRICE_W + 2 + QTY_W;
    localparam int TICK      = 1;
    localparam int BOT_QTY   = 10;
    localparam int COOLDOWN  = 4;
    localparam int POS_W     = 16;
    localparam int POS_LIMIT = 100;
    localparam int POS_SAT   = 32767;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic [1:0] mode;
    logic signed [POS_W-1:0] position;
    logic [31:0] orders_sent;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    quote_strategy_bot_if #(.PRICE_W(PRICE_W), .QTY_W(QTY_W)) bus ();

    quote_strategy_bot #(
        .PRICE_W(PRICE_W), .QTY_W(QTY_W), .TICK(TICK), .BOT_QTY(BOT_QTY),
        .COOLDOWN(COOLDOWN), .POS_W(POS_W), .POS_LIMIT(POS_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .bus         (bus),
        .position    (position),
        .orders_sent (orders_sent),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_pos    = 0;
    logic [31:0] m_orders = '0;
    bit          m_last_side = 1'b0;
    logic [ORD_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ORD_W-1:0] mk_root(input int px, input bit is_bot,
                                                input bit empty, input bit side);
        logic [15:0] p;
        p = px[15:0];
        if (empty) return '0;
        return {p, side, is_bot, 14'd5};
    endfunction

    // Quoting rules in plain integer arithmetic: which side (if any) gets an
    // order, at what price, and how many cycles after eligibility it appears.
    function automatic void predict(input int md, input int bpx, input bit bbot, input bit bempty,
                                    input int apx, input bit abot, input bit aempty,
                                    input int pos, input bit lside,
                                    output bit ok, output bit side, output int price,
                                    output int lat);
        bit improve;
        bit first;
        bit s;
        bit q;
        int tgt;
        ok = 0; side = 0; price = 0; lat = 0;
        if (md == 0 || bempty || aempty) return;
        improve = (md == 1) || (md == 3);
        first   = (md == 3) ? !lside : 1'b1;
        for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? first : !first;
            if (s) begin
                tgt = bpx + (improve ? TICK : 0);
                q = !bbot && (tgt < 65536) && (tgt < apx) && (pos + BOT_QTY <= POS_LIMIT);
            end else begin
                tgt = apx - (improve ? TICK : 0);
                q = !abot && (!improve || apx > TICK) && (tgt > bpx) && (pos - BOT_QTY >= -POS_LIMIT);
            end
            if (q) begin
                ok = 1; side = s; price = tgt; lat = 3 + i;
                return;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_fill(input bit is_buy, input int qty);
        logic [QTY_W-1:0] q;
        q = qty[QTY_W-1:0];
        bus.fill_valid  = 1'b1;
        bus.fill_is_buy = is_buy;
        bus.fill_qty    = q;
        @(negedge clk);
        bus.fill_valid  = 1'b0;
        m_pos = is_buy ? m_pos + qty : m_pos - qty;
        if (m_pos > POS_SAT) m_pos = POS_SAT;
        if (m_pos < -POS_SAT) m_pos = -POS_SAT;
        check("position_fill", 64'($signed(position)), 64'(m_pos));
    endtask

    task automatic run_scenario(input int md, input int bpx, input bit bbot, input bit bempty,
                                input int apx, input bit abot, input bit aempty, input int n_orders);
        bit ok;
        bit side;
        int price;
        int lat;
        int exp_wait;
        int waited;
        int limit;
        int strays;
        bit seen;
        logic [15:0] p16;
        logic [ORD_W-1:0] exp_word;
        mode = md[1:0];
        bus.bid_root = mk_root(bpx, bbot, bempty, 1'b1);
        bus.ask_root = mk_root(apx, abot, aempty, 1'b0);
        enable = 1'b1;
        for (int k = 0; k < n_orders; k++) begin
            predict(md, bpx, bbot, bempty, apx, abot, aempty, m_pos, m_last_side, ok, side, price, lat);
            exp_wait = (k == 0) ? lat : COOLDOWN + lat;
            limit    = ok ? exp_wait + 6 : 12;
            seen = 0;
            waited = 0;
            while (!seen && waited < limit) begin
                @(negedge clk);
                waited++;
                seen = bus.bot_valid;
            end
            if (!ok) begin
                check("no_order", 64'(seen), 64'(0));
                break;
            end
            check("order_seen", 64'(seen), 64'(1));
            if (!seen) break;
            check("latency", 64'(waited), 64'(exp_wait));
            p16 = price[15:0];
            exp_q.push_back({p16, side, 1'b1, 14'(BOT_QTY)});
            exp_word = exp_q.pop_front();
            check("bot_data", 64'(bus.bot_data), 64'(exp_word));
            m_orders++;
            m_last_side = side;
            check("orders_sent", 64'(orders_sent), 64'(m_orders));
            if (k == n_orders - 1) enable = 1'b0;
        end
        enable = 1'b0;
        strays = 0;
        repeat (COOLDOWN + 6) begin
            @(negedge clk);
            if (bus.bot_valid) strays++;
        end
        check("stray_strobe", 64'(strays), 64'(0));
        check("idle_after", 64'(dbg_state), 64'(ST_IDLE));
    endtask

    task automatic blocked_check(input int which);
        int strays;
        mode = MODE_FRONT;
        bus.bid_root = mk_root(100, 0, 0, 1'b1);
        bus.ask_root = mk_root(105, 0, 0, 1'b0);
        if (which == 0) bus.bot_full = 1'b1;
        else            bus.engine_busy = 1'b1;
        enable = 1'b1;
        strays = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.bot_valid) strays++;
        end
        check(which == 0 ? "blocked_full" : "blocked_busy", 64'(strays), 64'(0));
        enable = 1'b0;
        bus.bot_full = 1'b0;
        bus.engine_busy = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int bpx;
        int apx;
        rst = 1'b1;
        enable = 1'b0;
        mode = MODE_OFF;
        bus.bid_root = '0;
        bus.ask_root = '0;
        bus.udp_fifo_has_data = 1'b0;
        bus.engine_busy = 1'b0;
        bus.bot_full = 1'b0;
        bus.fill_valid = 1'b0;
        bus.fill_is_buy = 1'b0;
        bus.fill_qty = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus.bot_valid), 64'(0));
        check("rst_data", 64'(bus.bot_data), 64'(0));
        check("rst_position", 64'($signed(position)), 64'(0));
        check("rst_orders", 64'(orders_sent), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Directed book scenarios
        run_scenario(1, 100, 0, 0, 105, 0, 0, 1);     // front bid 101
        run_scenario(1, 104, 0, 0, 105, 0, 0, 1);     // locked-ish book: nothing
        run_scenario(3, 100, 0, 0, 110, 0, 0, 3);     // alternating sides
        run_scenario(2, 100, 0, 0, 110, 0, 0, 1);     // join bid 100
        apply_fill(1'b1, 50);
        apply_fill(1'b1, 45);
        run_scenario(2, 100, 0, 0, 110, 0, 0, 1);     // bid blocked by position -> ask 110
        apply_fill(1'b0, 95);
        run_scenario(1, 100, 1, 0, 110, 0, 0, 1);     // bot bid root ignored -> ask 109
        run_scenario(1, 100, 0, 0, 110, 1, 0, 1);     // bot ask root ignored -> bid 101
        run_scenario(1, 65535, 0, 0, 65535, 0, 0, 1); // bid carry out: nothing
        run_scenario(1, 100, 0, 1, 110, 0, 0, 1);     // empty bid book: nothing
        run_scenario(0, 100, 0, 0, 110, 0, 0, 1);     // mode off: nothing
        blocked_check(0);
        blocked_check(1);

        // UDP traffic appears during SEND: order dropped, FSM idle
        mode = MODE_FRONT;
        bus.bid_root = mk_root(100, 0, 0, 1'b1);
        bus.ask_root = mk_root(105, 0, 0, 1'b0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("udp_in_send", 64'(dbg_state), 64'(ST_SEND));
        bus.udp_fifo_has_data = 1'b1;
        @(negedge clk);
        check("udp_no_strobe", 64'(bus.bot_valid), 64'(0));
        check("udp_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("udp_orders", 64'(orders_sent), 64'(m_orders));
        enable = 1'b0;
        bus.udp_fifo_has_data = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during cool-down with a simultaneous fill
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_strobe", 64'(bus.bot_valid), 64'(1));
        rst = 1'b1;
        enable = 1'b0;
        bus.fill_valid = 1'b1;
        bus.fill_is_buy = 1'b1;
        bus.fill_qty = 14'd7;
        @(negedge clk);
        check("rst_cool_valid", 64'(bus.bot_valid), 64'(0));
        check("rst_cool_data", 64'(bus.bot_data), 64'(0));
        check("rst_cool_position", 64'($signed(position)), 64'(0));
        check("rst_cool_orders", 64'(orders_sent), 64'(0));
        check("rst_cool_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;
        bus.fill_valid = 1'b0;
        m_pos = 0;
        m_orders = '0;
        m_last_side = 1'b0;
        @(negedge clk);
        run_scenario(3, 100, 0, 0, 110, 0, 0, 2);     // alternation restarts with bid

        // Random book scenarios
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 2) == 0) apply_fill($urandom_range(0, 1) == 1, $urandom_range(1, 60));
            if (m_pos > 150) apply_fill(1'b0, m_pos);
            if (m_pos < -150) apply_fill(1'b1, -m_pos);
            bpx = $urandom_range(1, 400);
            apx = bpx + int'($urandom_range(0, 5)) - 1;
            if ($urandom_range(0, 11) == 0) begin
                bpx = 65535;
                apx = 65535 - int'($urandom_range(0, 1));
            end
            run_scenario($urandom_range(1, 3), bpx, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                         apx, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, $urandom_range(1, 3));
        end

        // Position saturation in both directions, then back to flat
        if (m_pos != 0) apply_fill(m_pos < 0, (m_pos < 0) ? -m_pos : m_pos);
        repeat (3) apply_fill(1'b1, 16383);
        repeat (5) apply_fill(1'b0, 16383);
        repeat (2) apply_fill(1'b1, 16383);
        apply_fill(1'b1, 1);
        run_scenario(1, 200, 0, 0, 210, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
